// File: rtl/uart_rom_loader.sv
// UART boot loader: 8N1 receiver plus framing FSM that writes little-endian 32-bit words into the ROM.
// Optional feature: define UART_LOADER_CKSUM_EN to require a trailing 8-bit checksum byte.
module uart_rom_loader #(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned MAX_WORDS   = 4096,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          uart_rx,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          halt_req_o,
    output logic          reset_req_o,
    output logic          busy_o,
    output logic          err_o
);
    localparam int unsigned   CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned   CW           = $clog2(CLKS_PER_BIT);
    localparam int unsigned   TW           = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST      = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        P_IDLE = 3'd0,
        P_LEN0 = 3'd1,
        P_LEN1 = 3'd2,
        P_DATA = 3'd3,
        P_FIN  = 3'd4,
        P_DONE = 3'd5
    } p_state_t;

    function automatic logic [AW-1:0] word_addr(input logic [15:0] idx);
        return AW'(BASE_ADDR) + AW'({idx, 2'b00});
    endfunction

    function automatic logic [7:0] cksum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    rx_state_t     rx_state_r;
    logic          rx_meta_r, rx_sync_r, rx_prev_r;
    logic [CW-1:0] bit_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    rx_shift_r;
    logic [7:0]    rx_byte_r;
    logic          rx_valid_r;
    logic          rx_ferr_r;

    p_state_t      p_state_r;
    logic [15:0]   len_r;
    logic [15:0]   idx_r;
    logic [1:0]    byte_cnt_r;
    logic [DW-1:0] word_r;
    logic [TW-1:0] timer_r;

    logic [15:0]   len_full_s;
    logic [15:0]   idx_inc_s;
    logic [DW-1:0] word_next_s;

    assign len_full_s  = {rx_byte_r, len_r[7:0]};
    assign idx_inc_s   = idx_r + 16'd1;
    assign word_next_s = {rx_byte_r, word_r[DW-1:8]};

    // Two-flop synchroniser plus one delayed sample for falling-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Bit-level 8N1 receiver: start re-check at half bit, then sample at every bit centre
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state_r <= RX_IDLE;
            bit_cnt_r  <= '0;
            bit_idx_r  <= 3'd0;
            rx_shift_r <= 8'd0;
            rx_byte_r  <= 8'd0;
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    bit_cnt_r <= '0;
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end else begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (bit_cnt_r == HALF_LAST) begin
                        bit_cnt_r <= '0;
                        bit_idx_r <= 3'd0;
                        // A line that is already high again was only a glitch
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_r  <= '0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        bit_idx_r  <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_r  <= '0;
                        rx_state_r <= RX_IDLE;
                        if (rx_sync_r) begin
                            rx_valid_r <= 1'b1;
                            rx_byte_r  <= rx_shift_r;
                        end else begin
                            rx_ferr_r <= 1'b1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

`ifdef UART_LOADER_CKSUM_EN
    logic [7:0] cksum_r;

    // Running sum of every byte that follows the sync byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cksum_r <= 8'd0;
        end else if (rx_valid_r) begin
            if (p_state_r == P_IDLE) begin
                cksum_r <= 8'd0;
            end else if (p_state_r == P_LEN0 || p_state_r == P_LEN1 || p_state_r == P_DATA) begin
                cksum_r <= cksum_add(cksum_r, rx_byte_r);
            end
        end
    end
`endif

    // Protocol FSM: sync, length, word assembly, ROM writes, completion and error exits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_state_r   <= P_IDLE;
            len_r       <= 16'd0;
            idx_r       <= 16'd0;
            byte_cnt_r  <= 2'd0;
            word_r      <= '0;
            timer_r     <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            halt_req_o  <= 1'b0;
            reset_req_o <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            mem_we_o    <= 1'b0;
            reset_req_o <= 1'b0;
            if (p_state_r == P_IDLE || rx_valid_r) begin
                timer_r <= '0;
            end else begin
                timer_r <= timer_r + TW'(1);
            end

            if (rx_ferr_r || (p_state_r != P_IDLE && !rx_valid_r && timer_r == TO_LAST)) begin
                err_o      <= 1'b1;
                p_state_r  <= P_IDLE;
                halt_req_o <= 1'b0;
                busy_o     <= 1'b0;
            end else begin
                case (p_state_r)
                    P_IDLE: begin
                        if (rx_valid_r && rx_byte_r == 8'hA5) begin
                            p_state_r  <= P_LEN0;
                            err_o      <= 1'b0;
                            halt_req_o <= 1'b1;
                            busy_o     <= 1'b1;
                            idx_r      <= 16'd0;
                            byte_cnt_r <= 2'd0;
                        end
                    end
                    P_LEN0: begin
                        if (rx_valid_r) begin
                            len_r[7:0] <= rx_byte_r;
                            p_state_r  <= P_LEN1;
                        end
                    end
                    P_LEN1: begin
                        if (rx_valid_r) begin
                            len_r <= len_full_s;
                            if (32'(len_full_s) > MAX_WORDS) begin
                                err_o      <= 1'b1;
                                p_state_r  <= P_IDLE;
                                halt_req_o <= 1'b0;
                                busy_o     <= 1'b0;
                            end else if (len_full_s == 16'd0) begin
                                p_state_r <= P_FIN;
                            end else begin
                                p_state_r <= P_DATA;
                            end
                        end
                    end
                    P_DATA: begin
                        if (rx_valid_r) begin
                            if (byte_cnt_r == 2'd3) begin
                                mem_we_o    <= 1'b1;
                                mem_addr_o  <= word_addr(idx_r);
                                mem_wdata_o <= word_next_s;
                                idx_r       <= idx_inc_s;
                                byte_cnt_r  <= 2'd0;
                                if (idx_inc_s == len_r) begin
                                    p_state_r <= P_FIN;
                                end
                            end else begin
                                byte_cnt_r <= byte_cnt_r + 2'd1;
                                word_r     <= word_next_s;
                            end
                        end
                    end
                    P_FIN: begin
`ifdef UART_LOADER_CKSUM_EN
                        if (rx_valid_r) begin
                            if (rx_byte_r == cksum_r) begin
                                p_state_r   <= P_DONE;
                                reset_req_o <= 1'b1;
                            end else begin
                                err_o      <= 1'b1;
                                p_state_r  <= P_IDLE;
                                halt_req_o <= 1'b0;
                                busy_o     <= 1'b0;
                            end
                        end
`else
                        p_state_r   <= P_DONE;
                        reset_req_o <= 1'b1;
`endif
                    end
                    P_DONE: begin
                        p_state_r  <= P_IDLE;
                        halt_req_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end
                    default: begin
                        p_state_r  <= P_IDLE;
                        halt_req_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader at 16 clk/bit; checksum cases compile in with UART_LOADER_CKSUM_EN.
module tb_uart_rom_loader;
    logic        clk;
    logic        rstn;
    logic        uart_rx;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        halt_req_o;
    logic        reset_req_o;
    logic        busy_o;
    logic        err_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          rst_cnt = 0;
    int          both_cnt = 0;
    bit          halt_seen = 1'b0;

    typedef struct packed {
        logic [95:0] img;
        logic [3:0]  n;
        logic [3:0]  bad;
        logic        cks;
        logic [1:0]  nw;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [31:0] d1;
        logic        rst;
        logic        err;
    } vec_t;

    vec_t vecs [5];

    uart_rom_loader #(
        .CLK_FREQ(16),
        .BAUD(1),
        .TIMEOUT_CYC(400)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .uart_rx(uart_rx),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .halt_req_o(halt_req_o),
        .reset_req_o(reset_req_o),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish, required finish before 5ms");
        $fatal(1, "watchdog");
    end

    // Write/pulse monitor sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (mem_we_o) begin
                wr_addr_q.push_back(mem_addr_o);
                wr_data_q.push_back(mem_wdata_o);
            end
            if (reset_req_o) rst_cnt++;
            if (mem_we_o && reset_req_o) both_cnt++;
            if (halt_req_o) halt_seen = 1'b1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        rst_cnt   = 0;
        both_cnt  = 0;
        halt_seen = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        uart_rx = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(posedge clk);
        end
        uart_rx = bad_stop ? 1'b0 : 1'b1;
        repeat (16) @(posedge clk);
        uart_rx = 1'b1;
    endtask

    function automatic logic [7:0] img_cksum(input logic [95:0] img, input int n);
        logic [7:0] s = 8'd0;
        bit seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (seen) s = s + img[8*k +: 8];
            else if (img[8*k +: 8] == 8'hA5) seen = 1'b1;
        end
        return s;
    endfunction

    task automatic send_img(input logic [95:0] img, input int n, input int bad, input bit cks);
        for (int k = 0; k < n; k++) send_byte(img[8*k +: 8], k == bad);
`ifdef UART_LOADER_CKSUM_EN
        if (cks) send_byte(img_cksum(img, n), 1'b0);
`else
        if (cks && n > 12) send_byte(img_cksum(img, n), 1'b0);
`endif
    endtask

    task automatic check_result(input string tag, input int nw, input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [31:0] d1, input int rst, input logic err);
        logic [31:0] ea;
        logic [31:0] ed;
        @(negedge clk);
        check({tag, " writes"}, 32'(wr_addr_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            ea = (i == 0) ? a0 : a1;
            ed = (i == 0) ? d0 : d1;
            check($sformatf("%s addr%0d", tag, i), wr_addr_q[i], ea);
            check($sformatf("%s data%0d", tag, i), wr_data_q[i], ed);
        end
        check({tag, " reset_req"}, 32'(rst_cnt), 32'(rst));
        check({tag, " we&rst overlap"}, 32'(both_cnt), 32'd0);
        check({tag, " err"}, 32'(err_o), 32'(err));
        check({tag, " halt"}, 32'(halt_req_o), 32'd0);
        check({tag, " busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        vecs[0] = '{img: 96'h00DEADBEEF123456780002A5, n: 4'd11, bad: 4'hF, cks: 1'b1, nw: 2'd2,
                    a0: 32'h0, d0: 32'h12345678, a1: 32'h4, d1: 32'hDEADBEEF, rst: 1'b1, err: 1'b0};
        vecs[1] = '{img: 96'h000000443322110001A5FF00, n: 4'd9, bad: 4'hF, cks: 1'b1, nw: 2'd1,
                    a0: 32'h0, d0: 32'h44332211, a1: 32'h0, d1: 32'h0, rst: 1'b1, err: 1'b0};
        vecs[2] = '{img: 96'h0000000000443322110001A5, n: 4'd7, bad: 4'd6, cks: 1'b0, nw: 2'd0,
                    a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0, rst: 1'b0, err: 1'b1};
        vecs[3] = '{img: 96'h1001A5, n: 4'd3, bad: 4'hF, cks: 1'b0, nw: 2'd0,
                    a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0, rst: 1'b0, err: 1'b1};
        vecs[4] = '{img: 96'h0000A5, n: 4'd3, bad: 4'hF, cks: 1'b1, nw: 2'd0,
                    a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0, rst: 1'b1, err: 1'b0};

        rstn    = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset we", 32'(mem_we_o), 32'd0);
        check("reset addr", mem_addr_o, 32'd0);
        check("reset wdata", mem_wdata_o, 32'd0);
        check("reset halt", 32'(halt_req_o), 32'd0);
        check("reset rreq", 32'(reset_req_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        rstn = 1'b1;
        repeat (20) @(posedge clk);

        for (int v = 0; v < 5; v++) begin
            clear_mon();
            send_img(vecs[v].img, int'(vecs[v].n), int'(vecs[v].bad), vecs[v].cks);
            repeat (40) @(posedge clk);
            check_result($sformatf("vec%0d", v), int'(vecs[v].nw), vecs[v].a0, vecs[v].d0,
                         vecs[v].a1, vecs[v].d1, int'(vecs[v].rst), vecs[v].err);
            check($sformatf("vec%0d halt seen", v), 32'(halt_seen), 32'd1);
            repeat (20) @(posedge clk);
        end

        // Timeout after a partial word
        clear_mon();
        send_img(96'h110001A5, 4, -1, 1'b0);
        repeat (300) @(negedge clk);
        check("timeout early halt", 32'(halt_req_o), 32'd1);
        check("timeout early err", 32'(err_o), 32'd0);
        repeat (150) @(posedge clk);
        check_result("timeout", 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b1);

        // Short glitch in idle must not disturb the following load
        clear_mon();
        @(posedge clk);
        uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        uart_rx = 1'b1;
        repeat (20) @(posedge clk);
        send_img(96'hDDCCBBAA0001A5, 7, -1, 1'b1);
        repeat (40) @(posedge clk);
        check_result("glitch", 1, 32'h0, 32'hDDCCBBAA, 32'h0, 32'h0, 1, 1'b0);

        // Reset in the middle of the third word
        clear_mon();
        send_img(96'h01DEADBEEF123456780003A5, 12, -1, 1'b0);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst writes", 32'(wr_addr_q.size()), 32'd2);
        check("midrst halt before", 32'(halt_req_o), 32'd1);
        check("midrst busy before", 32'(busy_o), 32'd1);
        rstn = 1'b0;
        #1;
        check("midrst we", 32'(mem_we_o), 32'd0);
        check("midrst addr", mem_addr_o, 32'd0);
        check("midrst wdata", mem_wdata_o, 32'd0);
        check("midrst halt", 32'(halt_req_o), 32'd0);
        check("midrst busy", 32'(busy_o), 32'd0);
        check("midrst err", 32'(err_o), 32'd0);
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        clear_mon();
        repeat (200) @(negedge clk);
        check("postrst idle writes", 32'(wr_addr_q.size()), 32'd0);
        send_img(96'h443322110001A5, 7, -1, 1'b1);
        repeat (40) @(posedge clk);
        check_result("postrst load", 1, 32'h0, 32'h44332211, 32'h0, 32'h0, 1, 1'b0);

`ifdef UART_LOADER_CKSUM_EN
        clear_mon();
        send_img(96'h040302010001A5, 7, -1, 1'b0);
        send_byte(8'h0B, 1'b0);
        repeat (40) @(posedge clk);
        check_result("cksum ok", 1, 32'h0, 32'h04030201, 32'h0, 32'h0, 1, 1'b0);
        clear_mon();
        send_img(96'h040302010001A5, 7, -1, 1'b0);
        send_byte(8'h0C, 1'b0);
        repeat (40) @(posedge clk);
        check_result("cksum bad", 1, 32'h0, 32'h04030201, 32'h0, 32'h0, 0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
